// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and the writeback record used by the register-file write-port arbiter.
package regfile_wb_arbiter_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_rec_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module wb_sync_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately left out of reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU results (unstallable) beat buffered load results.
// Optional WB_STATS_EN adds a saturating counter of cycles in which a queued load was deferred.
module regfile_wb_arbiter #(
   parameter int LDQ_DEPTH = 2,
   parameter int XLEN      = regfile_wb_arbiter_pkg::XLEN
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [XLEN-1:0] ld_data,
   input  logic            ld_issue_valid,
   input  logic [4:0]      ld_issue_rd,
   output logic [31:0]     busy_mask,
   output logic [4:0]      w_addr,
   output logic [XLEN-1:0] w_data,
   output logic            w_enable
`ifdef WB_STATS_EN
   ,
   output logic [31:0]     ld_defer_cnt
`endif
);

   import regfile_wb_arbiter_pkg::*;

   wb_rec_t               ld_rec;
   wb_rec_t               head;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  sel_valid;
   logic [REG_ADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;
   logic [NUM_REGS-1:0]   busy_next;

   assign ld_rec   = '{rd: ld_rd, data: ld_data};
   assign ld_ready = !full && !rst;
   assign push     = ld_valid && ld_ready;
   assign pop      = !empty && !alu_valid;

   wb_sync_fifo #(
      .DEPTH (LDQ_DEPTH),
      .WIDTH ($bits(wb_rec_t))
   ) u_ldq (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (ld_rec),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
      if (alu_valid) begin
         sel_valid = 1'b1;
      end else if (pop) begin
         sel_valid = 1'b1;
         sel_rd    = head.rd;
         sel_data  = head.data;
      end
   end

   // A slot targeting x0 is consumed but never strobes the register file.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_enable <= 1'b0;
         w_addr   <= '0;
         w_data   <= '0;
      end else begin
         w_enable <= sel_valid && (sel_rd != '0);
         if (sel_valid && (sel_rd != '0)) begin
            w_addr <= sel_rd;
            w_data <= sel_data;
         end
      end
   end

   // Clear for the dequeued load first, then the new issue, so a same-cycle set wins.
   always_comb begin
      busy_next = busy_mask;
      if (pop)            busy_next[head.rd]     = 1'b0;
      if (ld_issue_valid) busy_next[ld_issue_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_mask <= '0;
      else     busy_mask <= busy_next;
   end

`ifdef WB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)
         ld_defer_cnt <= '0;
      else if (!empty && alu_valid && (ld_defer_cnt != '1))
         ld_defer_cnt <= ld_defer_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write scoreboard and a reference load queue.
// Build with WB_STATS_EN defined to also check ld_defer_cnt.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   localparam int LDQ_DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            ld_valid;
   logic            ld_ready;
   logic [4:0]      ld_rd;
   logic [XLEN-1:0] ld_data;
   logic            ld_issue_valid;
   logic [4:0]      ld_issue_rd;
   logic [31:0]     busy_mask;
   logic [4:0]      w_addr;
   logic [XLEN-1:0] w_data;
   logic            w_enable;
`ifdef WB_STATS_EN
   logic [31:0]     ld_defer_cnt;
`endif

   regfile_wb_arbiter #(.LDQ_DEPTH(LDQ_DEPTH), .XLEN(XLEN)) dut (
      .clk            (clk),
      .rst            (rst),
      .alu_valid      (alu_valid),
      .alu_rd         (alu_rd),
      .alu_data       (alu_data),
      .ld_valid       (ld_valid),
      .ld_ready       (ld_ready),
      .ld_rd          (ld_rd),
      .ld_data        (ld_data),
      .ld_issue_valid (ld_issue_valid),
      .ld_issue_rd    (ld_issue_rd),
      .busy_mask      (busy_mask),
      .w_addr         (w_addr),
      .w_data         (w_data),
      .w_enable       (w_enable)
`ifdef WB_STATS_EN
      ,
      .ld_defer_cnt   (ld_defer_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   wb_rec_t     m_ldq[$];
   wb_rec_t     exp_q[$];
   logic [31:0] m_busy;
   logic [31:0] m_defer;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check ld_ready, advance the reference model, then score the registered outputs.
   task automatic cycle();
      wb_rec_t r;
      logic    ready_pre;
      logic    exp_wen;
      int      pre_size;
      #1;
      pre_size  = m_ldq.size();
      ready_pre = !rst && (pre_size < LDQ_DEPTH);
      chk("ld_ready", {63'd0, ld_ready}, {63'd0, ready_pre});
      exp_wen = 1'b0;
      if (rst) begin
         m_ldq.delete();
         exp_q.delete();
         m_busy  = '0;
         m_defer = '0;
      end else begin
         if (alu_valid) begin
            if (alu_rd != 0) begin
               exp_q.push_back('{rd: alu_rd, data: alu_data});
               exp_wen = 1'b1;
            end
            if (pre_size > 0 && m_defer != 32'hFFFF_FFFF) m_defer++;
         end else if (pre_size > 0) begin
            r = m_ldq.pop_front();
            if (r.rd != 0) begin
               exp_q.push_back(r);
               exp_wen = 1'b1;
            end
            m_busy[r.rd] = 1'b0;
         end
         if (ld_valid && ready_pre) m_ldq.push_back('{rd: ld_rd, data: ld_data});
         if (ld_issue_valid) m_busy[ld_issue_rd] = 1'b1;
         m_busy[0] = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("w_enable", {63'd0, w_enable}, {63'd0, exp_wen});
      if (rst) begin
         chk("rst_w_addr", {59'd0, w_addr}, 64'd0);
         chk("rst_w_data", w_data, 64'd0);
      end else if (exp_wen) begin
         r = exp_q.pop_front();
         chk("w_addr", {59'd0, w_addr}, {59'd0, r.rd});
         chk("w_data", w_data, r.data);
      end
      chk("busy_mask", {32'd0, busy_mask}, {32'd0, m_busy});
`ifdef WB_STATS_EN
      chk("ld_defer_cnt", {32'd0, ld_defer_cnt}, {32'd0, m_defer});
`endif
   endtask

   task automatic idle_inputs();
      alu_valid      = 1'b0;
      alu_rd         = '0;
      alu_data       = '0;
      ld_valid       = 1'b0;
      ld_rd          = '0;
      ld_data        = '0;
      ld_issue_valid = 1'b0;
      ld_issue_rd    = '0;
   endtask

   initial begin
      logic [4:0] lds [3];
      int         ld_idx;
      m_busy  = '0;
      m_defer = '0;
      idle_inputs();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();

      // ALU only: write one cycle later, then idle holds address/data.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
      cycle();
      chk("alu_w_addr", {59'd0, w_addr}, 64'd5);
      chk("alu_w_data", w_data, 64'h1234);
      idle_inputs();
      cycle();
      chk("idle_w_enable", {63'd0, w_enable}, 64'd0);
      chk("idle_hold_addr", {59'd0, w_addr}, 64'd5);
      chk("idle_hold_data", w_data, 64'h1234);

      // Contention: one load against four ALU cycles.
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'hAA;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'(100 + i);
         cycle();
         ld_valid = 1'b0;
      end
      idle_inputs();
      cycle();
      chk("cont_ld_wen", {63'd0, w_enable}, 64'd1);
      chk("cont_ld_addr", {59'd0, w_addr}, 64'd7);
      chk("cont_ld_data", w_data, 64'hAA);
`ifdef WB_STATS_EN
      chk("cont_defer_cnt", {32'd0, ld_defer_cnt}, 64'd3);
`endif

      // FIFO full: three loads offered under continuous ALU traffic; the producer holds on !ld_ready.
      lds[0] = 5'd10; lds[1] = 5'd11; lds[2] = 5'd12;
      ld_idx = 0;
      for (int i = 0; i < 8; i++) begin
         alu_valid = (i < 4);
         alu_rd    = 5'd1;
         alu_data  = 64'(200 + i);
         ld_valid  = (ld_idx < 3);
         ld_rd     = (ld_idx < 3) ? lds[ld_idx] : 5'd0;
         ld_data   = 64'(16'hD000 + ld_idx);
         #1;
         if (i == 2) chk("full_ld_ready", {63'd0, ld_ready}, 64'd0);
         if (ld_valid && ld_ready) ld_idx++;
         cycle();
      end
      idle_inputs();
      cycle();
      chk("full_loads_taken", 64'(ld_idx), 64'd3);
      chk("full_ready_back", {63'd0, ld_ready}, 64'd1);

      // Scoreboard set, clear on writeback, and set-wins-over-clear.
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
      cycle();
      chk("sb_set", {32'd0, busy_mask}, 64'h200);
      idle_inputs();
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h99;
      cycle();
      idle_inputs();
      cycle();
      chk("sb_clear_wen", {63'd0, w_enable}, 64'd1);
      chk("sb_clear_mask", {32'd0, busy_mask}, 64'h0);
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
      cycle();
      idle_inputs();
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h98;
      cycle();
      idle_inputs();
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
      cycle();
      chk("sb_setwins_wen", {63'd0, w_enable}, 64'd1);
      chk("sb_setwins_mask", {32'd0, busy_mask}, 64'h200);
      idle_inputs();
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h97;
      cycle();
      idle_inputs();
      cycle();

      // x0: ALU and load with rd=0 never strobe and never mark busy.
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h5555;
      cycle();
      idle_inputs();
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 64'h6666;
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
      cycle();
      idle_inputs();
      cycle();
      chk("x0_busy", {32'd0, busy_mask}, 64'd0);
      chk("x0_wen", {63'd0, w_enable}, 64'd0);
      cycle();

      // Reset mid-stream with two loads queued and x5/x6 busy.
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd5;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'h11;
      ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 64'h55;
      cycle();
      ld_issue_rd = 5'd6;
      ld_rd = 5'd6; ld_data = 64'h66;
      cycle();
      chk("pre_rst_busy", {32'd0, busy_mask}, 64'h60);
      idle_inputs();
      rst = 1'b1;
      #1;
      chk("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
      cycle();
      chk("rst_busy", {32'd0, busy_mask}, 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {63'd0, ld_ready}, 64'd1);
      for (int i = 0; i < 3; i++) cycle();
      chk("post_rst_no_write", {63'd0, w_enable}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
